// File: rtl/rs_syndrome_16_8.sv
// RS(16,8) syndrome calculator: Horner evaluation of the received word at
// a^1..a^8 over GF(2^8)/0x11d, one symbol per accepted beat.
// Ports: clk, rst_n (sync, active-low); din_val/din_sop/din symbol stream
// (first accepted symbol is the x^15 coefficient); syn_val 1-cycle strobe,
// syn[8i-1:8i-8]=S_i, syn_nz error flag; frm_err abort/orphan strobe.
// Optional: define RS_SYN_FRAME_CHK_EN to build truncated-frame and
// orphan-symbol detection on frm_err (otherwise frm_err is tied low).
module rs_syndrome_16_8 #(
   parameter int N_NUM = 16,
   parameter int R_NUM = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               din_val,
   input  logic               din_sop,
   input  logic [7:0]         din,
   output logic               syn_val,
   output logic [8*R_NUM-1:0] syn,
   output logic               syn_nz,
   output logic               frm_err
);

   localparam int CW = $clog2(N_NUM);
   localparam logic [CW-1:0] LAST = CW'(N_NUM - 1);

   // multiply by a^p: p repeated xtime steps (p is a constant per use)
   function automatic logic [7:0] mul_pow(input logic [7:0] a,
                                          input int p);
      logic [7:0] r;
      r = a;
      for (int k = 0; k < p; k++)
         r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1d : 8'h00);
      return r;
   endfunction

   logic [CW-1:0]           sym_cnt_q, sym_cnt_d;
   logic [R_NUM-1:0][7:0]   acc_q, acc_d, horner;
   logic [8*R_NUM-1:0]      syn_q, syn_d;
   logic                    syn_nz_q, syn_nz_d;
   logic                    syn_val_q, syn_val_d;
   logic                    busy, start, step, fin;

   assign busy  = (sym_cnt_q != '0);
   assign start = din_val & din_sop;
   assign step  = din_val & ~din_sop & busy & (sym_cnt_q != LAST);
   assign fin   = din_val & ~din_sop & (sym_cnt_q == LAST);

   always_comb begin
      horner = '0;
      for (int i = 0; i < R_NUM; i++)
         horner[i] = mul_pow(acc_q[i], i + 1) ^ din;
   end

   always_comb begin
      acc_d     = acc_q;
      sym_cnt_d = sym_cnt_q;
      syn_d     = syn_q;
      syn_nz_d  = syn_nz_q;
      syn_val_d = 1'b0;
      if (start) begin
         // sop reloads every accumulator, discarding any partial frame
         for (int i = 0; i < R_NUM; i++)
            acc_d[i] = din;
         sym_cnt_d = CW'(1);
      end else if (step) begin
         acc_d     = horner;
         sym_cnt_d = sym_cnt_q + CW'(1);
      end else if (fin) begin
         syn_d     = horner;
         syn_nz_d  = |horner;
         syn_val_d = 1'b1;
         sym_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q     <= '0;
         sym_cnt_q <= '0;
         syn_q     <= '0;
         syn_nz_q  <= 1'b0;
         syn_val_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         sym_cnt_q <= sym_cnt_d;
         syn_q     <= syn_d;
         syn_nz_q  <= syn_nz_d;
         syn_val_q <= syn_val_d;
      end
   end

   assign syn_val = syn_val_q;
   assign syn     = syn_q;
   assign syn_nz  = syn_nz_q;

`ifdef RS_SYN_FRAME_CHK_EN
   logic frm_err_q, frm_err_d;

   // truncated frame (sop while busy) or orphan symbol (no sop while idle)
   assign frm_err_d = (start & busy) | (din_val & ~din_sop & ~busy);

   always_ff @(posedge clk) begin
      if (!rst_n) frm_err_q <= 1'b0;
      else        frm_err_q <= frm_err_d;
   end

   assign frm_err = frm_err_q;
`else
   assign frm_err = 1'b0;
`endif

endmodule

// File: tb/tb_rs_syndrome_16_8.sv
// Scoreboard bench for rs_syndrome_16_8.
// Driver pushes expected syndromes; monitor pops on syn_val/frm_err.
module tb_rs_syndrome_16_8;

   typedef logic [7:0] cw_t [16];
   typedef logic [7:0] msg_t [8];
   typedef struct {
      logic [63:0] syn;
      logic        nz;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        din_val, din_sop;
   logic [7:0]  din;
   logic        syn_val, syn_nz, frm_err;
   logic [63:0] syn;

   int unsigned cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int ferr_seen = 0;
   int ferr_exp = 0;
   exp_t        sq[$];
   int unsigned fq[$];
   int unsigned pcyc[$];

   rs_syndrome_16_8 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .din_val (din_val),
      .din_sop (din_sop),
      .din     (din),
      .syn_val (syn_val),
      .syn     (syn),
      .syn_nz  (syn_nz),
      .frm_err (frm_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p, x;
      p = 0;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] gpow(input int e);
      logic [7:0] r;
      r = 8'h01;
      for (int k = 0; k < e % 255; k++) r = gmul(r, 8'h02);
      return r;
   endfunction

   // direct power-sum: S_i = sum c_j * a^(i*(15-j))
   function automatic logic [63:0] syn_model(input cw_t cw);
      logic [63:0] r;
      logic [7:0]  s;
      r = '0;
      for (int i = 1; i <= 8; i++) begin
         s = 0;
         for (int j = 0; j < 16; j++)
            s ^= gmul(cw[j], gpow(i * (15 - j)));
         r[8*i-1 -: 8] = s;
      end
      return r;
   endfunction

   // systematic encoder, g(x) = prod (x + a^i), i=1..8
   function automatic void encode(input msg_t m, output cw_t cw);
      logic [7:0] g [9];
      logic [7:0] r [8];
      logic [7:0] fb;
      for (int k = 0; k < 9; k++) g[k] = 0;
      g[0] = 8'h01;
      for (int i = 1; i <= 8; i++) begin
         for (int k = i; k >= 1; k--)
            g[k] = g[k-1] ^ gmul(g[k], gpow(i));
         g[0] = gmul(g[0], gpow(i));
      end
      for (int k = 0; k < 8; k++) r[k] = 0;
      for (int j = 0; j < 8; j++) begin
         fb = m[j] ^ r[7];
         for (int k = 7; k >= 1; k--)
            r[k] = r[k-1] ^ gmul(fb, g[k]);
         r[0] = gmul(fb, g[0]);
      end
      for (int j = 0; j < 8; j++) cw[j] = m[j];
      for (int j = 0; j < 8; j++) cw[8+j] = r[7-j];
   endfunction

   task automatic beat(input logic sop, input logic [7:0] d);
      din_val = 1'b1;
      din_sop = sop;
      din     = d;
      @(negedge clk);
      din_val = 1'b0;
      din_sop = 1'b0;
      din     = 8'h00;
   endtask

   task automatic send(input cw_t cw, input int nb, input bit gaps,
                       input logic [63:0] req);
      exp_t e;
      for (int j = 0; j < nb; j++) begin
         if (gaps && j > 0)
            repeat ($urandom_range(0, 3)) @(negedge clk);
         if (j == 15) begin
            e.syn = req;
            e.nz  = |req;
            e.cyc = cyc + 1;
            sq.push_back(e);
         end
         beat(j == 0, cw[j]);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (syn_val === 1'b1) begin
         pcyc.push_back(cyc);
         if (sq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_syn_val: got strobe at cycle %0d, required none", cyc);
         end else begin
            e = sq.pop_front();
            chk("syn", syn, e.syn);
            chk("syn_nz", {63'd0, syn_nz}, {63'd0, e.nz});
            chk("syn_val_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      if (frm_err === 1'b1) begin
         ferr_seen++;
         if (fq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frm_err: got pulse at cycle %0d, required none", cyc);
         end else begin
            chk("frm_err_cycle", 64'(cyc), 64'(fq.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      cw_t  z, c, t;
      msg_t m;
      logic [63:0] r;
      rst_n   = 1'b0;
      din_val = 1'b0;
      din_sop = 1'b0;
      din     = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_syn_val", {63'd0, syn_val}, 64'd0);
      chk("rst_syn", syn, 64'd0);
      chk("rst_syn_nz", {63'd0, syn_nz}, 64'd0);
      chk("rst_frm_err", {63'd0, frm_err}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int j = 0; j < 16; j++) z[j] = 8'h00;
      send(z, 16, 0, 64'h0);
      @(negedge clk);

      c = z;
      c[15] = 8'h01;
      send(c, 16, 0, 64'h0101010101010101);
      @(negedge clk);

      c = z;
      c[0] = 8'h01;
      r = syn_model(c);
      send(c, 16, 0, {r[63:16], 8'h60, 8'h26});
      @(negedge clk);

      for (int j = 0; j < 8; j++) m[j] = 8'(j + 1);
      encode(m, c);
      send(c, 16, 1, 64'h0);
      @(negedge clk);
      t = c;
      t[2] = t[2] ^ 8'h5a;
      send(t, 16, 1, syn_model(t));
      repeat (2) @(negedge clk);

      // back-to-back: zero frame then single error, no bubble
      c = z;
      c[5] = 8'h01;
      send(z, 16, 0, 64'h0);
      send(c, 16, 0, syn_model(c));
      repeat (2) @(negedge clk);
      if (pcyc.size() >= 2)
         chk("b2b_spacing", 64'(pcyc[$] - pcyc[$-1]), 64'd16);
      else
         chk("b2b_pulses", 64'(pcyc.size()), 64'd2);

      // reset in the middle of a third frame
      send(t, 9, 0, 64'h0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_syn", syn, 64'd0);
      chk("midrst_syn_nz", {63'd0, syn_nz}, 64'd0);
      chk("midrst_syn_val", {63'd0, syn_val}, 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // truncated frame: new sop arrives as symbol 7
      send(t, 6, 0, 64'h0);
`ifdef RS_SYN_FRAME_CHK_EN
      fq.push_back(cyc + 1);
      ferr_exp++;
`endif
      send(c, 16, 0, syn_model(c));
      repeat (4) @(negedge clk);

      chk("pending_syn", 64'(sq.size()), 64'd0);
      chk("pending_frm_err", 64'(fq.size()), 64'd0);
      chk("frm_err_count", 64'(ferr_seen), 64'(ferr_exp));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
